// File: rtl/audio_mux_nch.sv
// N-channel audio sample mux: coherent per-frame snapshots read over a 32-bit register bus,
// plus jack-mode FIFO refill trigger generation with overrun detection.
//   state | meaning
//   IDLE  | no refill in progress; trig follows lrck when buffersize==0
//   FILL  | issuing run triggers until counter reaches buffersize
module audio_mux_nch #(
   parameter int NUM_CH        = 8,
   parameter int AUD_BIT_DEPTH = 24,
   parameter int FIFO_WIDTH    = 6,
   parameter int ADDR_WIDTH    = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [ADDR_WIDTH-1:0]           address,
   input  logic                            read,
   input  logic                            write,
   input  logic [31:0]                     datain,
   input  logic [NUM_CH*AUD_BIT_DEPTH-1:0] sound_in,
   input  logic                            sound_valid,
   input  logic                            xxxx_top,
   input  logic                            lrck,
   input  logic                            run,
   output logic [31:0]                     dataout,
   output logic [NUM_CH-1:0]               ch_read,
   output logic                            trig,
   output logic                            i2s_enable,
   output logic [31:0]                     samplerate,
   output logic                            fill_active,
   output logic                            overrun
);

   localparam int CW = FIFO_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(NUM_CH);
   localparam logic [ADDR_WIDTH-1:0] A_BUF    = ADDR_WIDTH'(NUM_CH + 1);
   localparam logic [ADDR_WIDTH-1:0] A_RATE   = ADDR_WIDTH'(NUM_CH + 2);
   localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(NUM_CH + 3);

   typedef enum logic {IDLE, FILL} state_t;

   state_t                     state_q, state_d;
   logic [CW-1:0]              counter_q, counter_d;
   logic                       run_trig_q, run_trig_d;
   logic                       overrun_q, overrun_d;
   logic                       jra_q, jra_dly_q;
   logic [CW-1:0]              buffersize_q;
   logic [31:0]                samplerate_q;
   logic [31:0]                dataout_q, rdata_d;
   logic [AUD_BIT_DEPTH-1:0]   snap_q [NUM_CH];

   logic wr_ctrl, wr_buf, wr_rate, jack_cycle_end;

   assign wr_ctrl        = write && (address == A_CTRL);
   assign wr_buf         = write && (address == A_BUF);
   assign wr_rate        = write && (address == A_RATE);
   assign jack_cycle_end = jra_dly_q && !jra_q;

   always_comb begin
      state_d    = state_q;
      counter_d  = counter_q;
      run_trig_d = 1'b0;
      overrun_d  = overrun_q;
      if (wr_ctrl && datain[1])
         overrun_d = 1'b0;
      if (state_q == IDLE) begin
         if (jack_cycle_end && (buffersize_q != '0)) begin
            state_d   = FILL;
            counter_d = '0;
         end
      end else begin
         // a new cycle end while still refilling wins over the clear (set priority)
         if (jack_cycle_end) begin
            overrun_d = 1'b1;
            counter_d = '0;
         end else if (counter_q >= buffersize_q) begin
            state_d = IDLE;
         end else if (xxxx_top && !run) begin
            run_trig_d = 1'b1;
            counter_d  = counter_q + CW'(1);
         end
      end
   end

   always_comb begin
      rdata_d = '0;
      for (int k = 0; k < NUM_CH; k++)
         if (address == ADDR_WIDTH'(k))
            rdata_d = 32'(snap_q[k]) << (32 - AUD_BIT_DEPTH);
      if (address == A_CTRL)   rdata_d = {31'b0, jra_q};
      if (address == A_BUF)    rdata_d = 32'(buffersize_q);
      if (address == A_RATE)   rdata_d = samplerate_q;
      if (address == A_STATUS)
         rdata_d = (32'(counter_q) << 8) | {30'b0, (state_q == FILL), overrun_q};
   end

   always_comb begin
      ch_read = '0;
      for (int k = 0; k < NUM_CH; k++)
         ch_read[k] = read && (address == ADDR_WIDTH'(k));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         counter_q    <= '0;
         run_trig_q   <= 1'b0;
         overrun_q    <= 1'b0;
         jra_q        <= 1'b0;
         jra_dly_q    <= 1'b0;
         buffersize_q <= '0;
         samplerate_q <= '0;
         dataout_q    <= '0;
         for (int k = 0; k < NUM_CH; k++)
            snap_q[k] <= '0;
      end else begin
         state_q    <= state_d;
         counter_q  <= counter_d;
         run_trig_q <= run_trig_d;
         overrun_q  <= overrun_d;
         jra_dly_q  <= jra_q;
         if (wr_ctrl) jra_q        <= datain[0];
         if (wr_buf)  buffersize_q <= datain[FIFO_WIDTH:0];
         if (wr_rate) samplerate_q <= datain;
         if (read)    dataout_q    <= rdata_d;
         if (sound_valid)
            for (int k = 0; k < NUM_CH; k++)
               snap_q[k] <= sound_in[k*AUD_BIT_DEPTH +: AUD_BIT_DEPTH];
      end
   end

   assign dataout     = dataout_q;
   assign samplerate  = samplerate_q;
   assign i2s_enable  = (buffersize_q == '0);
   assign trig        = i2s_enable ? lrck : run_trig_q;
   assign fill_active = (state_q == FILL);
   assign overrun     = overrun_q;

endmodule

// File: doc/audio_mux_nch.md
Name: audio_mux_nch

Overview:
Parametrised N-channel successor to the stereo audio mux. Each channel's sample is snapshotted coherently per frame and read back over a 32-bit register bus. The block also holds the jack control, buffersize and samplerate registers. It produces the sample trigger: in i2s mode the trigger is lrck; in buffered (jack) mode it is a counted burst of run triggers that refills the FIFO after each jack read cycle, with overrun detection and a status register.

Parameters:
NUM_CH, 8, number of audio channels (>=2)
AUD_BIT_DEPTH, 24, sample width, <=32
FIFO_WIDTH, 6, buffersize/counter width is FIFO_WIDTH+1 bits
ADDR_WIDTH, 4, register address width; 2**ADDR_WIDTH >= NUM_CH+4

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
address  in  ADDR_WIDTH  register address
read  in  1  register read strobe
write  in  1  register write strobe
datain  in  32  write data
sound_in  in  NUM_CH*AUD_BIT_DEPTH  channel samples; channel k at bits [k*AUD_BIT_DEPTH +: AUD_BIT_DEPTH]
sound_valid  in  1  frame strobe; snapshot all channels
xxxx_top  in  1  synth cycle-top strobe, paces run triggers
lrck  in  1  i2s word clock
run  in  1  synth busy; blocks run triggers
dataout  out  32  registered read data
ch_read  out  NUM_CH  one-hot: read && address==k
trig  out  1  sample trigger
i2s_enable  out  1  high when buffersize==0
samplerate  out  32  samplerate register
fill_active  out  1  FSM in FILL
overrun  out  1  sticky overrun flag

Behaviour:
- Reset (async, immediate): dataout=0, samplerate=0, buffersize=0, jack_read_act=0 and its delay=0, counter=0, run_trig=0, state=IDLE, overrun=0, all snapshots=0. Consequence: i2s_enable=1 and trig=lrck right after reset. Reset mid-fill aborts the fill with no residual trigger.
- Register map (A=NUM_CH):
  - 0..A-1 R: channel snapshot, left-justified in dataout[31:32-AUD_BIT_DEPTH], low bits 0.
  - A W: bit0=jack_read_act, bit1=1 clears overrun. R: {31'b0, jack_read_act}.
  - A+1 RW: buffersize = datain[FIFO_WIDTH:0].
  - A+2 RW: samplerate, full 32 bits.
  - A+3 R: bit0=overrun, bit1=fill_active, bits[8+FIFO_WIDTH:8]=counter, others 0. Writes ignored.
  - Unmapped reads return 0; unmapped writes are ignored.
- Read latency: 1 cycle; dataout updates on the clk edge where read=1 and holds otherwise. ch_read is combinational.
- Snapshot: on sound_valid, all NUM_CH channels latch together. A read in the same cycle returns the pre-update snapshot.
- jack_cycle_end = jack_read_act_dly && !jack_read_act, using a one-cycle registered delay.
- Mode: buffersize==0 gives trig=lrck (combinational pass) and i2s_enable=1. Otherwise trig=run_trig (registered) and i2s_enable=0.
- FSM states IDLE, FILL:
  - IDLE -> FILL on jack_cycle_end with buffersize!=0; counter<=0.
  - FILL -> IDLE when counter>=buffersize, which includes buffersize being rewritten at or below the count or to 0.
  - In FILL, jack_cycle_end sets overrun, resets counter to 0 and stays in FILL.
  - jack_cycle_end in IDLE with buffersize==0: no effect.
- run_trig: 1-cycle pulse registered when state==FILL && xxxx_top && !run && counter<buffersize. counter increments on that same edge, so counter always equals trigs issued this cycle. At most one pulse per xxxx_top cycle. Consecutive xxxx_top cycles give consecutive pulses.
- counter does not wrap: it saturates at buffersize because the FSM leaves FILL.
- overrun: set-priority. A clear and a new overrun in the same cycle leaves overrun=1.
- samplerate uses nonblocking update and appears on the output one cycle after the write.

Test Plan:
- Reset, then lrck toggling, no writes -> i2s_enable=1, trig follows lrck, dataout=0, fill_active=0.
- NUM_CH=8, sound_in ch3=24'hABCDEF, pulse sound_valid, read addr 3 -> next cycle dataout=32'hABCDEF00, ch_read=8'b00001000. Change sound_in without sound_valid and reread -> same value.
- Write buffersize=4, write ctrl 1 then 0; hold xxxx_top=1, run=0 -> exactly 4 trig pulses, status counter=4, fill_active falls after the 4th.
- Fill with buffersize=8 and run=1 for 10 cycles -> no trig while run=1; pulses resume when run=0; total 8.
- Second jack_cycle_end after 3 pulses -> overrun=1, counter restarts, 8 more pulses. Write ctrl bit1=1 -> overrun=0. Clear coincident with a new cycle end -> overrun stays 1.
- Assert reset mid-fill after 2 pulses -> state IDLE, buffersize=0, trig=lrck, overrun=0 immediately.
